// File: rtl/da_pkg.sv
// Shared types and elaboration-time helpers for the distributed-arithmetic DCT datapath.
// da_entry builds one subset-sum ROM word from a packed coefficient vector.
package da_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [15:0] C4_Q14 = 16'h2D41;

    // Widest packed coefficient vector da_entry can consume.
    localparam int unsigned COEF_MAX_W = 4096;

    function automatic int unsigned rw_f(input int unsigned cw, input int unsigned n);
        return cw + $clog2(n);
    endfunction

    function automatic int unsigned aw_f(input int unsigned cw, input int unsigned n,
                                         input int unsigned dw);
        return rw_f(cw, n) + dw;
    endfunction

    // Sum of C[r][k] for every k whose address bit a[n-1-k] is set, sign-extended to 64 bits.
    function automatic logic [63:0] da_entry(input logic [COEF_MAX_W-1:0] coef,
                                             input int unsigned n, input int unsigned cw,
                                             input int unsigned r, input int unsigned a);
        logic [63:0] sum;
        logic [63:0] elem;
        logic [63:0] mask;
        sum  = '0;
        mask = (64'd1 << cw) - 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            if (a[n-1-k]) begin
                elem = 64'(coef >> ((r * n + k) * cw)) & mask;
                if (elem[cw-1]) begin
                    elem = elem | ~mask;
                end
                sum = sum + elem;
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/da_coef_rom.sv
// Combinational subset-sum coefficient ROM, one 2^N-entry bank per coefficient row.
// Rows at or beyond ROWS read as zero.
module da_coef_rom
    import da_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned ROWS = 8,
    parameter logic [ROWS*N*CW-1:0] COEF = '0,
    localparam int unsigned RW  = rw_f(CW, N),
    localparam int unsigned RSW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic [RSW-1:0] row,
    input  logic [N-1:0]   addr,
    output logic [RW-1:0]  entry
);

    localparam int unsigned BANK  = 2 ** N;
    localparam int unsigned DEPTH = ROWS * BANK;
    localparam logic [COEF_MAX_W-1:0] COEF_X = COEF_MAX_W'(COEF);

    logic [RW-1:0] rom_tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [63:0] E = da_entry(COEF_X, N, CW, i / BANK, i % BANK);
        assign rom_tbl[i] = E[RW-1:0];
    end

    always_comb begin
        entry = '0;
        if (32'(row) < ROWS) begin
            entry = rom_tbl[{row, addr}];
        end
    end

endmodule

// File: rtl/da_dct_mac.sv
// Bit-serial distributed-arithmetic dot product: one sample bit-plane per clock, LSB first,
// with the sample MSB plane subtracted for two's-complement weighting.
module da_dct_mac
    import da_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 16,
    parameter int unsigned ROWS = 8,
    parameter logic [ROWS*N*CW-1:0] COEF = '0,
    localparam int unsigned RW  = rw_f(CW, N),
    localparam int unsigned AW  = aw_f(CW, N, DW),
    localparam int unsigned RSW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      x_in,
    input  logic [RSW-1:0]       row_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] y,
    output logic                 out_err
);

    localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

    state_e                state_q, state_d;
    logic [BW-1:0]         b_q, b_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [N*DW-1:0]       x_q, x_d;
    logic [RSW-1:0]        row_q, row_d;
    logic                  err_q, err_d;

    logic [N-1:0]          rom_addr;
    logic [RW-1:0]         rom_entry;
    logic signed [AW-1:0]  term;

    da_coef_rom #(
        .N    (N),
        .CW   (CW),
        .ROWS (ROWS),
        .COEF (COEF)
    ) u_rom (
        .row   (row_q),
        .addr  (rom_addr),
        .entry (rom_entry)
    );

    // x[0] feeds the address MSB.
    always_comb begin
        rom_addr = '0;
        for (int k = 0; k < N; k++) begin
            rom_addr[N-1-k] = x_q[k*DW + int'(b_q)];
        end
        term = AW'($signed(rom_entry)) <<< b_q;
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        acc_d   = acc_q;
        x_d     = x_q;
        row_d   = row_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    x_d     = x_in;
                    row_d   = row_sel;
                    b_d     = '0;
                    acc_d   = '0;
                    err_d   = (32'(row_sel) >= ROWS);
                end
            end
            SHIFT: begin
                if (32'(b_q) == DW - 1) begin
                    acc_d   = acc_q - term;
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + term;
                    b_d   = b_q + BW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign y         = acc_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_da_dct_mac.sv
// Directed bench for da_dct_mac: hand-computed dot products, latency, backpressure,
// out-of-range row and mid-computation reset.
module tb_da_dct_mac;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 16;
    // Three sets so a 2-bit row_sel has an unused code (3) for the error case.
    localparam int unsigned ROWS = 3;
    localparam int unsigned AW   = 26;

    // Element (r,k) at [(r*N+k)*CW +: CW]; row 2 = {1, 2, 4, 8}.
    localparam logic [ROWS*N*CW-1:0] COEF = {
        16'd8,     16'd4,     16'd2,     16'd1,
        16'h2D41,  16'hD2BF,  16'hD2BF,  16'h2D41,
        16'h2D41,  16'h2D41,  16'h2D41,  16'h2D41
    };

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      x_in;
    logic [1:0]           row_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] y;
    logic                 out_err;

    int checks   = 0;
    int failures = 0;

    da_dct_mac #(
        .N    (N),
        .DW   (DW),
        .CW   (CW),
        .ROWS (ROWS),
        .COEF (COEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_x(input logic [7:0] x0, input logic [7:0] x1,
                                                input logic [7:0] x2, input logic [7:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    // Send one vector with out_ready high; check latency, result, and return to IDLE.
    task automatic run_vec(input string tag, input logic [N*DW-1:0] xv, input logic [1:0] r,
                           input logic signed [63:0] ey, input logic ee);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        x_in     = xv;
        row_sel  = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_y"}, y, ey);
        check({tag, "_err"}, out_err, ee);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x_in      = '0;
        row_sel   = '0;
        out_ready = 1'b1;

        #2 check("rst_in_ready_low", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_err", out_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        run_vec("unit_row0", pack_x(8'd1, 8'd0, 8'd0, 8'd0), 2'd0, 11585, 1'b0);
        run_vec("neg128_row0", pack_x(8'h80, 8'h80, 8'h80, 8'h80), 2'd0, -5931520, 1'b0);
        run_vec("mixed_row1", pack_x(8'd10, 8'd20, 8'd5, 8'd40), 2'd1, 289625, 1'b0);
        run_vec("max_row1", pack_x(8'd127, 8'd127, 8'd127, 8'd127), 2'd1, 0, 1'b0);
        run_vec("small_row2", pack_x(8'd3, 8'hFF, 8'd0, 8'd2), 2'd2, 17, 1'b0);
        run_vec("bad_row", pack_x(8'd1, 8'd0, 8'd0, 8'd0), 2'd3, 0, 1'b1);

        // Backpressure: in_valid stays high with a different vector waiting.
        @(negedge clk);
        out_ready = 1'b0;
        x_in      = pack_x(8'd10, 8'd20, 8'd5, 8'd40);
        row_sel   = 2'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        x_in    = pack_x(8'd1, 8'd0, 8'd0, 8'd0);
        row_sel = 2'd0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
            check($sformatf("bp_hold_y_%0d", i), y, 289625);
            check($sformatf("bp_hold_in_ready_%0d", i), in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_consumed_valid", out_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("bp_no_second_accept", in_ready, 1);
        out_ready = 1'b1;

        // Reset on the 4th SHIFT edge discards the partial result.
        @(negedge clk);
        x_in     = pack_x(8'd10, 8'd20, 8'd5, 8'd40);
        row_sel  = 2'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_err", out_err, 0);
        check("midrst_in_ready_low", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_idle", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("midrst_no_emit", seen, 0);
        run_vec("after_rst", pack_x(8'd1, 8'd0, 8'd0, 8'd0), 2'd0, 11585, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
